// File: rtl/spi_txn_sequencer.sv
// Command sequencer in front of the SPI controller: accepts one request, pulses
// start, tracks busy with a watchdog, returns the received bytes, then enforces an idle gap.
`timescale 1ns/1ps
module spi_txn_sequencer #(
   parameter int NUM_BYTES      = 2,
   parameter int PERIPH_DEVICES = 1,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int MIN_GAP        = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [PERIPH_DEVICES-1:0] req_cs,
   input  logic [1:0]                req_len,
   input  logic [8*NUM_BYTES-1:0]    req_data,
   output logic                      spi_scom,
   output logic [PERIPH_DEVICES-1:0] spi_cs,
   output logic [1:0]                spi_len,
   output logic [8*NUM_BYTES-1:0]    spi_tx,
   input  logic                      spi_busy,
   input  logic [8*NUM_BYTES-1:0]    spi_rx,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [8*NUM_BYTES-1:0]    rsp_data,
   output logic                      rsp_timeout,
   output logic [15:0]               txn_count,
   output logic [2:0]                dbg_state
);
   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // valid never waits on ready, and the producer holds its payload until the transfer.

   localparam int DW      = 8*NUM_BYTES;
   localparam int CNT_LIM = (TIMEOUT_CYCLES > MIN_GAP) ? TIMEOUT_CYCLES : MIN_GAP;
   localparam int CNT_W   = $clog2(CNT_LIM + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = (MIN_GAP > 0) ? CNT_W'(MIN_GAP - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_RESP      = 3'd4,
      S_GAP       = 3'd5
   } state_e;

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
   logic                      scom_q, scom_d;
   logic [PERIPH_DEVICES-1:0] cs_q, cs_d;
   logic [1:0]                len_q, len_d;
   logic [DW-1:0]             tx_q, tx_d;
   logic [DW-1:0]             rsp_data_q, rsp_data_d;
   logic                      rsp_to_q, rsp_to_d;
   logic [15:0]               txn_q, txn_d;
   logic                      accept, wait_expired;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         scom_q     <= 1'b0;
         cs_q       <= '1;
         len_q      <= '0;
         tx_q       <= '0;
         rsp_data_q <= '0;
         rsp_to_q   <= 1'b0;
         txn_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         scom_q     <= scom_d;
         cs_q       <= cs_d;
         len_q      <= len_d;
         tx_q       <= tx_d;
         rsp_data_q <= rsp_data_d;
         rsp_to_q   <= rsp_to_d;
         txn_q      <= txn_d;
      end
   end

   // The wait counter saturates so an oversized count can never wrap back into range.
   assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign wait_expired = (cnt_q == TO_LAST);
   assign accept       = (state_q == S_IDLE) && req_valid;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) state_d = S_LAUNCH;
         end
         S_LAUNCH: begin
            state_d = S_WAIT_BUSY;
            cnt_d   = '0;
         end
         S_WAIT_BUSY: begin
            if (spi_busy) begin
               state_d = S_WAIT_DONE;
               cnt_d   = '0;
            end else if (wait_expired) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         S_WAIT_DONE: begin
            if (!spi_busy || wait_expired) state_d = S_RESP;
            else                           cnt_d   = cnt_inc;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = (MIN_GAP == 0) ? S_IDLE : S_GAP;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      req_ready   = (state_q == S_IDLE);
      rsp_valid   = (state_q == S_RESP);
      spi_scom    = scom_q;
      spi_cs      = cs_q;
      spi_len     = len_q;
      spi_tx      = tx_q;
      rsp_data    = rsp_data_q;
      rsp_timeout = rsp_to_q;
      txn_count   = txn_q;
      dbg_state   = state_q;
   end

   // Response fields are written only on entry to RESP, so they stay stable while stalled.
   always_comb begin
      scom_d     = accept;
      cs_d       = accept ? req_cs   : cs_q;
      len_d      = accept ? req_len  : len_q;
      tx_d       = accept ? req_data : tx_q;
      rsp_data_d = rsp_data_q;
      rsp_to_d   = rsp_to_q;
      txn_d      = txn_q;
      if (state_q == S_WAIT_BUSY && !spi_busy && wait_expired) begin
         rsp_data_d = '0;
         rsp_to_d   = 1'b1;
      end
      if (state_q == S_WAIT_DONE) begin
         if (!spi_busy) begin
            rsp_data_d = spi_rx;
            rsp_to_d   = 1'b0;
         end else if (wait_expired) begin
            rsp_data_d = '0;
            rsp_to_d   = 1'b1;
         end
      end
      if (state_q == S_RESP && rsp_ready) txn_d = txn_q + 16'd1;
   end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Randomized bench for spi_txn_sequencer: a simple SPI controller model plus a
// timing/result reference derived from the watchdog and gap rules.
`timescale 1ns/1ps
module tb_spi_txn_sequencer;
   localparam int NB  = 2;
   localparam int PD  = 1;
   localparam int TO  = 8;
   localparam int GAP = 4;
   localparam int DW  = 8*NB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [PD-1:0] req_cs = '1;
   logic [1:0]    req_len = '0;
   logic [DW-1:0] req_data = '0;
   logic          spi_scom;
   logic [PD-1:0] spi_cs;
   logic [1:0]    spi_len;
   logic [DW-1:0] spi_tx;
   logic          spi_busy;
   logic [DW-1:0] spi_rx;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic          rsp_timeout;
   logic [15:0]   txn_count;
   logic [2:0]    dbg_state;

   spi_txn_sequencer #(
      .NUM_BYTES(NB), .PERIPH_DEVICES(PD), .TIMEOUT_CYCLES(TO), .MIN_GAP(GAP)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_cs(req_cs), .req_len(req_len), .req_data(req_data),
      .spi_scom(spi_scom), .spi_cs(spi_cs), .spi_len(spi_len), .spi_tx(spi_tx),
      .spi_busy(spi_busy), .spi_rx(spi_rx),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
      .txn_count(txn_count), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- controller model ----------------
   // ctl_t counts cycles since the start pulse (1 = first cycle after it).
   // Busy is high for ctl_len cycles starting at ctl_t == ctl_dly; the receive
   // buffer takes the new value on the same edge busy falls.
   int            ctl_t = 0;
   int            ctl_dly = 1000;
   int            ctl_len = 1;
   logic [DW-1:0] ctl_rx = '0;

   always @(posedge clk) begin
      if (!rst_n)                         ctl_t <= 0;
      else if (spi_scom)                  ctl_t <= 1;
      else if (ctl_t != 0 && ctl_t < 100000) ctl_t <= ctl_t + 1;
   end

   assign spi_busy = (ctl_t != 0) && (ctl_t >= ctl_dly) && (ctl_t < ctl_dly + ctl_len);
   assign spi_rx   = (ctl_t != 0 && ctl_t >= ctl_dly + ctl_len) ? ctl_rx : 16'hDEAD;

   // ---------------- scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   logic [15:0]   exp_txn = '0;
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: the sequencer waits up to TO cycles for busy to rise and up to TO
   // cycles for it to fall. lat = cycles from the start-pulse cycle to rsp_valid.
   function automatic void ref_txn(input int dly, input int blen, output bit to, output int lat);
      if (dly > TO) begin
         to  = 1'b1;
         lat = 1 + TO;
      end else if (blen > TO) begin
         to  = 1'b1;
         lat = dly + 1 + TO;
      end else begin
         to  = 1'b0;
         lat = dly + blen + 1;
      end
   endfunction

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_req_ready"},   req_ready,   1);
      check_eq({pfx, "_spi_scom"},    spi_scom,    0);
      check_eq({pfx, "_spi_cs"},      spi_cs,      {PD{1'b1}});
      check_eq({pfx, "_spi_len"},     spi_len,     0);
      check_eq({pfx, "_spi_tx"},      spi_tx,      0);
      check_eq({pfx, "_rsp_valid"},   rsp_valid,   0);
      check_eq({pfx, "_rsp_data"},    rsp_data,    0);
      check_eq({pfx, "_rsp_timeout"}, rsp_timeout, 0);
      check_eq({pfx, "_txn_count"},   txn_count,   0);
   endtask

   // ---------------- driver ----------------
   task automatic run_txn(input logic [PD-1:0] cs, input logic [1:0] len, input logic [DW-1:0] data,
                          input int dly, input int blen, input logic [DW-1:0] rx,
                          input int hold, input bit second_req);
      bit            to;
      int            lat;
      int            n;
      logic [DW-1:0] exp_d;
      ref_txn(dly, blen, to, lat);
      ctl_dly = dly;
      ctl_len = blen;
      ctl_rx  = rx;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("req_ready_idle", req_ready, 1);
      req_cs = cs; req_len = len; req_data = data; req_valid = 1'b1;
      exp_q.push_back(to ? '0 : rx);
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("scom_high", spi_scom, 1);
      check_eq("spi_tx", spi_tx, data);
      check_eq("spi_cs", spi_cs, cs);
      check_eq("spi_len", spi_len, len);
      check_eq("req_ready_busy", req_ready, 0);
      @(negedge clk);
      n = 1;
      check_eq("scom_one_cycle", spi_scom, 0);
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("rsp_latency", n, lat);
      exp_d = exp_q.pop_front();
      if (second_req) begin
         req_valid = 1'b1; req_data = ~data; req_cs = ~cs;
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("stall_rsp_valid", rsp_valid, 1);
         check_eq("stall_rsp_data", rsp_data, exp_d);
         check_eq("stall_req_ready", req_ready, 0);
         check_eq("stall_spi_tx", spi_tx, data);
      end
      check_eq("rsp_data", rsp_data, exp_d);
      check_eq("rsp_timeout", rsp_timeout, to);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      exp_txn++;
      check_eq("rsp_valid_drop", rsp_valid, 0);
      check_eq("txn_count", txn_count, exp_txn);
      n = 0;
      while (!req_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check_eq("gap_cycles", n, GAP);
      check_eq("spi_tx_hold", spi_tx, data);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      run_txn(1'b0, 2'd1, 16'h1234, 2, TO, 16'hA55A, 0, 1'b0);   // clean, busy exactly TO long
      run_txn(1'b0, 2'd0, 16'h00FF, 1000, 1, 16'h1111, 0, 1'b0); // busy never rises
      run_txn(1'b0, 2'd1, 16'hBEEF, 1, 1000, 16'h2222, 0, 1'b0); // busy stuck high
      run_txn(1'b0, 2'd1, 16'hCAFE, 1, 3, 16'h3C3C, 10, 1'b1);   // long stall with a second request
      run_txn(1'b0, 2'd1, 16'h0F0F, TO, 2, 16'h4B4B, 0, 1'b0);   // busy appears on last wait cycle
      run_txn(1'b0, 2'd1, 16'hF0F0, TO + 1, 2, 16'h5A5A, 0, 1'b0);
      run_txn(1'b0, 2'd1, 16'h7777, 3, TO + 1, 16'h6969, 0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         run_txn(PD'($urandom), 2'($urandom_range(0, 3)), DW'($urandom),
                 $urandom_range(1, TO + 2), $urandom_range(1, TO + 2), DW'($urandom),
                 $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Reset while the controller is busy: the transaction must vanish.
      ctl_dly = 2; ctl_len = 1000; ctl_rx = 16'h9999;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      req_cs = 1'b0; req_len = 2'd1; req_data = 16'h4321; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("pre_reset_rsp_valid", rsp_valid, 0);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      exp_txn = '0;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rsp_valid) n++;
      end
      check_eq("no_rsp_after_reset", n, 0);
      run_txn(1'b0, 2'd1, 16'hABCD, 2, 4, 16'h8181, 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
- Upstream command stage for the SPI controller. Accepts one transaction request at a time over a valid/ready handshake and launches it with a one-cycle start pulse.
- Tracks the controller's busy flag, captures the received bytes once it returns to idle, and returns them over a valid/ready response handshake.
- Adds a busy watchdog (timeout) and an enforced inter-transaction gap so chip-select deassert time is guaranteed between back-to-back transfers.

Parameters:
- NUM_BYTES, 2, bytes per transfer buffer; must match the controller.
- PERIPH_DEVICES, 1, chip-select width; must match the controller.
- TIMEOUT_CYCLES, 256, maximum cycles allowed in each wait state before the transaction is aborted; must be at least 2.
- MIN_GAP, 4, idle cycles enforced after each response handshake before the next request is accepted; 0 allowed.

Ports:
- clk  in  1  system clock; the same clock as the SPI controller.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_cs  in  PERIPH_DEVICES  chip-select pattern (active-low) forwarded to the controller.
- req_len  in  2  transfer length code; bytes = req_len+1.
- req_data  in  8*NUM_BYTES  transmit bytes.
- spi_scom  out  1  start pulse to the controller.
- spi_cs  out  PERIPH_DEVICES  latched req_cs.
- spi_len  out  2  latched req_len.
- spi_tx  out  8*NUM_BYTES  latched req_data.
- spi_busy  in  1  controller busy flag.
- spi_rx  in  8*NUM_BYTES  controller receive buffer.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  8*NUM_BYTES  received bytes; zero on timeout.
- rsp_timeout  out  1  response is an aborted transaction.
- txn_count  out  16  completed-response counter; wraps.

Behaviour:
- Reset (rst_n=0 sampled on a clk rising edge):
  - State goes to IDLE.
  - req_ready=1, spi_scom=0, spi_cs='1, spi_len=0, spi_tx=0.
  - rsp_valid=0, rsp_data=0, rsp_timeout=0, txn_count=0, all counters 0.
  - Reset mid-transaction drops the transaction silently; no response is produced.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_cs/len/data into spi_cs/spi_len/spi_tx, then go to LAUNCH.
- LAUNCH:
  - spi_scom=1 for exactly one cycle (registered, so it is high the cycle after acceptance).
  - Then go to WAIT_BUSY; the wait counter is cleared.
- WAIT_BUSY:
  - If spi_busy=1, go to WAIT_DONE and clear the wait counter.
  - Else increment the wait counter. When it reaches TIMEOUT_CYCLES-1, go to RESP with rsp_timeout=1 and rsp_data=0.
- WAIT_DONE:
  - If spi_busy=0, capture spi_rx into rsp_data, set rsp_timeout=0 and go to RESP. The controller updates its receive buffer on the same edge busy falls, so spi_rx is valid here.
  - Else increment the wait counter, with the same timeout rule as WAIT_BUSY.
- RESP:
  - rsp_valid=1; rsp_data and rsp_timeout are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: rsp_valid drops the next cycle, txn_count increments (also on timeout responses, wrapping 0xFFFF to 0), then go to GAP.
  - If MIN_GAP=0, go straight to IDLE instead of GAP.
- GAP:
  - Count MIN_GAP cycles, then go to IDLE. req_ready=0 for the whole state.
- req_ready is 1 only in IDLE, so requests are never accepted while a transaction is outstanding.
- spi_cs/spi_len/spi_tx hold their values from acceptance until the next acceptance.
- Latency on a clean path: acceptance at cycle N, spi_scom at N+1, rsp_valid on the cycle after the sequencer first sees spi_busy=0 in WAIT_DONE.
- If spi_busy is already 1 on entry to WAIT_BUSY, the sequencer moves to WAIT_DONE on the next edge.
- The wait counter must be wide enough for TIMEOUT_CYCLES and must saturate, never wrap.

Test Plan:
- Model the controller (busy high 2 cycles after scom, for 16 cycles, spi_rx=16'hA55A). Send req_data=16'h1234, req_len=1, req_cs=1'b0 -> spi_scom high exactly one cycle at N+1; spi_tx=16'h1234, spi_cs=0; rsp_data=16'hA55A, rsp_timeout=0; txn_count=1.
- Hold busy low forever, TIMEOUT_CYCLES=8 -> rsp_valid after 8 cycles in WAIT_BUSY; rsp_timeout=1; rsp_data=0.
- Stick busy high -> timeout from WAIT_DONE after TIMEOUT_CYCLES; rsp_timeout=1.
- Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable; req_ready=0; a second req_valid is not accepted.
- Two back-to-back requests, MIN_GAP=4 -> exactly 4 cycles with req_ready=0 after the first response handshake; second scom follows; txn_count=2.
- Assert rst_n=0 during WAIT_DONE -> next cycle all outputs at reset values; no rsp_valid; txn_count=0.
